// File: rtl/instr_fetch_if.sv
// Bus between the instruction fetch unit, instruction memory and control/datapath.
// With IFETCH_PERF_EN defined the bus also carries the bubble/stall performance counters.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  i_stall;
    logic                  i_jump;
    logic [ADDR_WIDTH-1:0] i_jumpTarget;
    logic                  i_branch;
    logic                  i_zero;
    logic [ADDR_WIDTH-1:0] i_branchOffset;
    logic [ADDR_WIDTH-1:0] o_imemAddr;
    logic [15:0]           i_imemData;
    logic [15:0]           o_instrCode;
    logic                  o_instrValid;
    logic [ADDR_WIDTH-1:0] o_pc;
`ifdef IFETCH_PERF_EN
    logic [15:0]           o_bubbleCount;
    logic [15:0]           o_stallCount;

    modport master (
        input  i_stall, i_jump, i_jumpTarget, i_branch, i_zero, i_branchOffset, i_imemData,
        output o_imemAddr, o_instrCode, o_instrValid, o_pc, o_bubbleCount, o_stallCount
    );
    modport slave (
        output i_stall, i_jump, i_jumpTarget, i_branch, i_zero, i_branchOffset, i_imemData,
        input  o_imemAddr, o_instrCode, o_instrValid, o_pc, o_bubbleCount, o_stallCount
    );
`else
    modport master (
        input  i_stall, i_jump, i_jumpTarget, i_branch, i_zero, i_branchOffset, i_imemData,
        output o_imemAddr, o_instrCode, o_instrValid, o_pc
    );
    modport slave (
        output i_stall, i_jump, i_jumpTarget, i_branch, i_zero, i_branchOffset, i_imemData,
        input  o_imemAddr, o_instrCode, o_instrValid, o_pc
    );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC, jump/branch redirect with one bubble, stall hold.
// Optional macro IFETCH_PERF_EN adds saturating bubble and stall counters.
module instr_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_PC   = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetchPc;
    logic [ADDR_WIDTH-1:0] reqPc;

    logic                  running;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;

    assign running  = (state == RUN);
    assign redirect = bus.i_jump || (bus.i_branch && bus.i_zero);
    // Jump wins over a simultaneous taken branch; arithmetic wraps at the PC width.
    assign target   = bus.i_jump ? bus.i_jumpTarget : (reqPc + PC_ONE + bus.i_branchOffset);

    assign bus.o_instrValid = running;
    assign bus.o_instrCode  = running ? bus.i_imemData : 16'h0000;
    assign bus.o_pc         = reqPc;
    // During a stall the memory re-reads the held address so the instruction stays stable.
    assign bus.o_imemAddr   = (running && bus.i_stall) ? reqPc : fetchPc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= BOOT;
            fetchPc <= PC_RESET;
            reqPc   <= PC_RESET;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.i_stall) begin
                        if (redirect) begin
                            fetchPc <= target;
                            state   <= FLUSH;
                        end else begin
                            reqPc   <= fetchPc;
                            fetchPc <= fetchPc + PC_ONE;
                        end
                    end
                end
                default: begin
                    reqPc   <= fetchPc;
                    fetchPc <= fetchPc + PC_ONE;
                    state   <= RUN;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] bubbleCount;
    logic [15:0] stallCount;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bubbleCount <= 16'h0000;
            stallCount  <= 16'h0000;
        end else begin
            if (state == FLUSH && bubbleCount != 16'hFFFF) begin
                bubbleCount <= bubbleCount + 16'h0001;
            end
            if (running && bus.i_stall && stallCount != 16'hFFFF) begin
                stallCount <= stallCount + 16'h0001;
            end
        end
    end

    assign bus.o_bubbleCount = bubbleCount;
    assign bus.o_stallCount  = stallCount;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized run against a PC-stream model.
module tb_instr_fetch;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    instr_fetch #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [15:0] mem [256];
    always @(posedge clk) bus.i_imemData <= mem[bus.o_imemAddr];

    int checks = 0;
    int errors = 0;

    task automatic setIn(input logic s, input logic j, input logic [7:0] jt,
                         input logic b, input logic z, input logic [7:0] off);
        bus.i_stall        = s;
        bus.i_jump         = j;
        bus.i_jumpTarget   = jt;
        bus.i_branch       = b;
        bus.i_zero         = z;
        bus.i_branchOffset = off;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        doReset();
        checks++;
        if (bus.o_instrValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", bus.o_instrValid);
        end
        checks++;
        if (bus.o_instrCode !== 16'h0000) begin
            errors++; $display("FAIL reset_code got %h want 0000", bus.o_instrCode);
        end
        checks++;
        if (bus.o_pc !== 8'h00 || bus.o_imemAddr !== 8'h00) begin
            errors++; $display("FAIL reset_pc got pc %h addr %h want 00 00", bus.o_pc, bus.o_imemAddr);
        end
        $display("test_reset done");
    endtask

    task automatic test_sequential;
        logic [7:0] k;
        doReset();
        for (int i = 0; i < 4; i++) begin
            tick();
            k = 8'(i);
            checks++;
            if (bus.o_instrValid !== 1'b1 || bus.o_pc !== k || bus.o_instrCode !== (16'h0400 + 16'(i))) begin
                errors++;
                $display("FAIL seq_%0d got valid %b pc %h code %h want 1 %h %h", i,
                         bus.o_instrValid, bus.o_pc, bus.o_instrCode, k, 16'h0400 + 16'(i));
            end
        end
        $display("test_sequential done");
    endtask

    // Leaves the unit showing o_pc=3 valid, then jumps to 8'h40.
    task automatic test_jump;
        doReset();
        repeat (4) tick();
        setIn(1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
        tick();
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.o_instrValid !== 1'b0 || bus.o_instrCode !== 16'h0000) begin
            errors++; $display("FAIL jump_bubble got valid %b code %h want 0 0000", bus.o_instrValid, bus.o_instrCode);
        end
        tick();
        checks++;
        if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h40 || bus.o_instrCode !== 16'h0440) begin
            errors++; $display("FAIL jump_target got valid %b pc %h code %h want 1 40 0440",
                               bus.o_instrValid, bus.o_pc, bus.o_instrCode);
        end
        $display("test_jump done");
    endtask

    task automatic gotoPc10;
        doReset();
        tick();
        setIn(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
        tick();
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_branch;
        gotoPc10();
        setIn(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFC);
        tick();
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.o_instrValid !== 1'b0) begin
            errors++; $display("FAIL branch_bubble got valid %b want 0", bus.o_instrValid);
        end
        tick();
        checks++;
        if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h0D || bus.o_instrCode !== 16'h040D) begin
            errors++; $display("FAIL branch_taken got valid %b pc %h code %h want 1 0d 040d",
                               bus.o_instrValid, bus.o_pc, bus.o_instrCode);
        end
        gotoPc10();
        setIn(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFC);
        tick();
        checks++;
        if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h11) begin
            errors++; $display("FAIL branch_not_taken got valid %b pc %h want 1 11", bus.o_instrValid, bus.o_pc);
        end
        gotoPc10();
        setIn(1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 8'hFC);
        tick();
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        tick();
        checks++;
        if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h40) begin
            errors++; $display("FAIL jump_over_branch got valid %b pc %h want 1 40", bus.o_instrValid, bus.o_pc);
        end
        $display("test_branch done");
    endtask

    task automatic test_stall;
        doReset();
        repeat (6) tick();
        // Redirect held together with stall must be ignored.
        setIn(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h05 || bus.o_instrCode !== 16'h0405
                || bus.o_imemAddr !== 8'h05) begin
                errors++; $display("FAIL stall_hold_%0d got valid %b pc %h code %h addr %h want 1 05 0405 05",
                                   i, bus.o_instrValid, bus.o_pc, bus.o_instrCode, bus.o_imemAddr);
            end
        end
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        tick();
        checks++;
        if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h06 || bus.o_instrCode !== 16'h0406) begin
            errors++; $display("FAIL stall_release got valid %b pc %h code %h want 1 06 0406",
                               bus.o_instrValid, bus.o_pc, bus.o_instrCode);
        end
        setIn(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
        tick();
        setIn(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
        tick();
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.o_instrValid !== 1'b0) begin
            errors++; $display("FAIL stall_redirect_bubble got valid %b want 0", bus.o_instrValid);
        end
        tick();
        checks++;
        if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h80) begin
            errors++; $display("FAIL stall_redirect_target got valid %b pc %h want 1 80", bus.o_instrValid, bus.o_pc);
        end
        $display("test_stall done");
    endtask

    task automatic test_wrap;
        logic [7:0] want [3];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00;
        doReset();
        tick();
        setIn(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h00);
        tick();
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.o_instrValid !== 1'b1 || bus.o_pc !== want[i]) begin
                errors++; $display("FAIL wrap_%0d got valid %b pc %h want 1 %h", i, bus.o_instrValid, bus.o_pc, want[i]);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_flush_reset;
        doReset();
        repeat (3) tick();
        setIn(1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
        tick();
        setIn(1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.o_instrValid !== 1'b0 || bus.o_pc !== 8'h00) begin
            errors++; $display("FAIL flush_reset got valid %b pc %h want 0 00", bus.o_instrValid, bus.o_pc);
        end
        tick();
        checks++;
        if (bus.o_instrValid !== 1'b1 || bus.o_pc !== 8'h00 || bus.o_instrCode !== 16'h0400) begin
            errors++; $display("FAIL flush_restart got valid %b pc %h code %h want 1 00 0400",
                               bus.o_instrValid, bus.o_pc, bus.o_instrCode);
        end
        $display("test_flush_reset done");
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf;
        test_jump();
        checks++;
        if (bus.o_bubbleCount !== 16'd1) begin
            errors++; $display("FAIL perf_bubbles got %0d want 1", bus.o_bubbleCount);
        end
        setIn(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        repeat (3) tick();
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.o_stallCount !== 16'd3) begin
            errors++; $display("FAIL perf_stalls got %0d want 3", bus.o_stallCount);
        end
        $display("test_perf done");
    endtask
`endif

    // Model: the unit shows a stream of PCs; a redirect inserts one invalid slot then resumes at the target.
    task automatic test_random;
        logic       mValid, nValid;
        logic [7:0] mPc, nPc, mTgt, nTgt, wantAddr;
        logic [15:0] wantCode;
        logic       r, s, j, b, z;
        logic [7:0] jt, off;
        doReset();
        mValid = 1'b0; mPc = 8'h00; mTgt = 8'h00;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 9) == 0);
            b   = ($urandom_range(0, 4) == 0);
            z   = $urandom_range(0, 1) == 1;
            jt  = 8'($urandom);
            off = 8'($urandom);
            setIn(s, j, jt, b, z, off);
            rst = r;
            nValid = mValid; nPc = mPc; nTgt = mTgt;
            if (r) begin
                nValid = 1'b0; nPc = 8'h00; nTgt = 8'h00;
            end else if (!mValid) begin
                nValid = 1'b1; nPc = mTgt;
            end else if (s) begin
                nValid = 1'b1;
            end else if (j) begin
                nValid = 1'b0; nTgt = jt;
            end else if (b && z) begin
                nValid = 1'b0; nTgt = 8'(mPc + 8'd1 + off);
            end else begin
                nPc = 8'(mPc + 8'd1);
            end
            tick();
            rst = 1'b0;
            mValid = nValid; mPc = nPc; mTgt = nTgt;
            wantCode = mValid ? mem[mPc] : 16'h0000;
            wantAddr = mValid ? (s ? mPc : 8'(mPc + 8'd1)) : mTgt;
            $display("txn %0d rst=%b stall=%b jump=%b br=%b z=%b -> valid=%b pc=%h code=%h",
                     n, r, s, j, b, z, bus.o_instrValid, bus.o_pc, bus.o_instrCode);
            checks++;
            if (bus.o_instrValid !== mValid || bus.o_pc !== mPc || bus.o_instrCode !== wantCode) begin
                errors++; $display("FAIL rand_out_%0d got valid %b pc %h code %h want %b %h %h", n,
                                   bus.o_instrValid, bus.o_pc, bus.o_instrCode, mValid, mPc, wantCode);
            end
            checks++;
            if (bus.o_imemAddr !== wantAddr) begin
                errors++; $display("FAIL rand_addr_%0d got %h want %h", n, bus.o_imemAddr, wantAddr);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'h0400 + 16'(k);
        rst = 1'b1;
        setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_stall();
        test_wrap();
        test_flush_reset();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
